// File: rtl/sram_chip_responder_pkg.sv
// Shared definitions for the sram_1Mx8 chip-side responder: default bus
// widths, statistics counter width, latency counter width and FSM encoding.
package sram_chip_responder_pkg;

  localparam int SRAM_ADDR_WIDTH = 20;
  localparam int SRAM_DATA_WIDTH = 8;
  localparam int SRAM_CNT_WIDTH  = 16;
  localparam int SRAM_LAT_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_READ_VALID = 2'd2,
    ST_WRITE      = 2'd3
  } sram_state_e;

  // Increment that sticks once the limit is reached.
  function automatic logic [SRAM_LAT_WIDTH-1:0] sat_inc(
    input logic [SRAM_LAT_WIDTH-1:0] v,
    input logic [SRAM_LAT_WIDTH-1:0] lim
  );
    return (v >= lim) ? v : v + SRAM_LAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/sram_resp_mem.sv
// Responder storage: 2**AW x DW array, one synchronous write port and one
// asynchronous read port. Contents survive reset.
module sram_resp_mem
  import sram_chip_responder_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = SRAM_DATA_WIDTH
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem_q [2**AW];

  // Write port: commit one word per enabled clock.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sram_chip_responder.sv
// Chip-side model of the async 1Mx8 SRAM seen from the controller pins.
// Optional build macro SRAM_RESP_TIMING_CHECK_EN: drop writes whose n_WE low
// pulse is shorter than MIN_WE_CYC samples and flag o_err_timing.
//
// state      | meaning
// IDLE       | bus released, waiting for n_WE or n_OE
// READ_WAIT  | access latency running; drives held data once cnt >= OE_LAT
// READ_VALID | driving mem[addr]
// WRITE      | n_WE low, latching address/data until n_WE rises
module sram_chip_responder
  import sram_chip_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int MEM_AWIDTH = 8,
  parameter int ACC_LAT    = 2,
  parameter int OE_LAT     = 1,
  parameter int MIN_WE_CYC = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  inout  wire  [DATA_WIDTH-1:0]     io_data,
  input  logic                      i_n_oe,
  input  logic                      i_n_we,
  output logic                      o_drive,
  output logic [SRAM_CNT_WIDTH-1:0] o_wr_count,
  output logic [SRAM_CNT_WIDTH-1:0] o_rd_count,
  output logic                      o_err_contention,
  output logic                      o_err_timing
);

  localparam int LW = SRAM_LAT_WIDTH;
  localparam logic [LW-1:0] ACC_LAST = LW'(ACC_LAT - 1);
  localparam logic [LW-1:0] OE_START = LW'(OE_LAT);

  if (ACC_LAT < 1 || OE_LAT < 1 || OE_LAT > ACC_LAT || MIN_WE_CYC < 1) begin : g_bad_param
    $error("sram_chip_responder: illegal latency parameters");
  end

  logic [ADDR_WIDTH-1:0]     s_addr_q;
  logic [DATA_WIDTH-1:0]     s_data_q;
  logic                      s_n_oe_q, s_n_we_q;
  sram_state_e               state_q, state_d;
  logic [LW-1:0]             cnt_q, cnt_d;
  logic                      drive_q, drive_d;
  logic [DATA_WIDTH-1:0]     dout_q, dout_d;
  logic [ADDR_WIDTH-1:0]     acc_addr_q, acc_addr_d;
  logic [MEM_AWIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [SRAM_CNT_WIDTH-1:0] wr_count_q, wr_count_d;
  logic [SRAM_CNT_WIDTH-1:0] rd_count_q, rd_count_d;
  logic                      err_c_q, err_c_d;
  logic                      wr_ok;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_rdata;

`ifdef SRAM_RESP_TIMING_CHECK_EN
  localparam logic [LW-1:0] MIN_L = LW'(MIN_WE_CYC);
  logic [LW-1:0] we_cnt_q, we_cnt_d;
  logic          err_t_q, err_t_d;
`endif

  sram_resp_mem #(
    .AW (MEM_AWIDTH),
    .DW (DATA_WIDTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (wr_addr_q),
    .i_wdata (wr_data_q),
    .i_raddr (s_addr_q[MEM_AWIDTH-1:0]),
    .o_rdata (mem_rdata)
  );

  // Pin sampling: every decision below works on these registered copies.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s_addr_q <= '0;
      s_data_q <= '0;
      s_n_oe_q <= 1'b1;
      s_n_we_q <= 1'b1;
    end else begin
      s_addr_q <= i_addr;
      s_data_q <= io_data;
      s_n_oe_q <= i_n_oe;
      s_n_we_q <= i_n_we;
    end
  end

  // FSM next state, latency counter, write latch, statistics and error flags.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drive_d    = drive_q;
    dout_d     = dout_q;
    acc_addr_d = acc_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    err_c_d    = err_c_q;
    mem_we     = 1'b0;
`ifdef SRAM_RESP_TIMING_CHECK_EN
    err_t_d  = err_t_q;
    we_cnt_d = s_n_we_q ? '0 : sat_inc(we_cnt_q, MIN_L);
    wr_ok    = (we_cnt_q >= MIN_L);
`else
    wr_ok    = 1'b1;
`endif

    // Last low sample of n_WE wins; overlap with our own drive is contention.
    if (!s_n_we_q) begin
      wr_addr_d = s_addr_q[MEM_AWIDTH-1:0];
      wr_data_d = s_data_q;
      if (drive_q) err_c_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!s_n_we_q) begin
          state_d = ST_WRITE;
        end else if (!s_n_oe_q) begin
          state_d    = ST_READ_WAIT;
          cnt_d      = '0;
          acc_addr_d = s_addr_q;
        end
      end
      ST_READ_WAIT, ST_READ_VALID: begin
        if (!s_n_we_q) begin
          state_d = ST_WRITE;
          drive_d = 1'b0;
        end else if (s_n_oe_q) begin
          state_d = ST_IDLE;
          drive_d = 1'b0;
        end else if (s_addr_q != acc_addr_q) begin
          // New address: restart latency but keep presenting the old word.
          state_d    = ST_READ_WAIT;
          cnt_d      = '0;
          acc_addr_d = s_addr_q;
        end else if (state_q == ST_READ_WAIT) begin
          cnt_d = cnt_q + LW'(1);
          if (cnt_d >= OE_START) drive_d = 1'b1;
          if (cnt_q == ACC_LAST) begin
            state_d    = ST_READ_VALID;
            dout_d     = mem_rdata;
            rd_count_d = rd_count_q + 1'b1;
            drive_d    = 1'b1;
          end
        end else begin
          dout_d = mem_rdata;
        end
      end
      ST_WRITE: begin
        if (s_n_we_q) begin
          if (wr_ok) begin
            mem_we     = 1'b1;
            wr_count_d = wr_count_q + 1'b1;
          end else begin
`ifdef SRAM_RESP_TIMING_CHECK_EN
            err_t_d = 1'b1;
`endif
          end
          state_d    = s_n_oe_q ? ST_IDLE : ST_READ_WAIT;
          cnt_d      = '0;
          acc_addr_d = s_addr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and status registers; reset discards any pending write.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      drive_q    <= 1'b0;
      dout_q     <= '0;
      acc_addr_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
      err_c_q    <= 1'b0;
`ifdef SRAM_RESP_TIMING_CHECK_EN
      we_cnt_q   <= '0;
      err_t_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drive_q    <= drive_d;
      dout_q     <= dout_d;
      acc_addr_q <= acc_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      err_c_q    <= err_c_d;
`ifdef SRAM_RESP_TIMING_CHECK_EN
      we_cnt_q   <= we_cnt_d;
      err_t_q    <= err_t_d;
`endif
    end
  end

  assign io_data          = drive_q ? dout_q : {DATA_WIDTH{1'bz}};
  assign o_drive          = drive_q;
  assign o_wr_count       = wr_count_q;
  assign o_rd_count       = rd_count_q;
  assign o_err_contention = err_c_q;
`ifdef SRAM_RESP_TIMING_CHECK_EN
  assign o_err_timing     = err_t_q;
`else
  assign o_err_timing     = 1'b0;
`endif

endmodule

// File: tb/tb_sram_chip_responder.sv
// Directed bench for sram_chip_responder with default parameters
// (ACC_LAT=2, OE_LAT=1, MEM_AWIDTH=8, MIN_WE_CYC=2).
module tb_sram_chip_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] addr = '0;
  logic        n_oe = 1'b1;
  logic        n_we = 1'b1;
  logic        tb_drv = 1'b0;
  logic [7:0]  tb_wdata = '0;
  wire  [7:0]  io_data;
  logic        drive;
  logic [15:0] wr_cnt, rd_cnt;
  logic        err_c, err_t;

  int compared   = 0;
  int mismatched = 0;

`ifdef SRAM_RESP_TIMING_CHECK_EN
  localparam logic [15:0] WR_AFTER_SHORT = 16'd4;
  localparam logic [7:0]  RD_AFTER_SHORT = 8'h77;
  localparam logic        ERR_T_SHORT    = 1'b1;
`else
  localparam logic [15:0] WR_AFTER_SHORT = 16'd5;
  localparam logic [7:0]  RD_AFTER_SHORT = 8'h99;
  localparam logic        ERR_T_SHORT    = 1'b0;
`endif

  always #5 clk = ~clk;

  assign io_data = tb_drv ? tb_wdata : 8'hzz;

  sram_chip_responder dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_addr           (addr),
    .io_data          (io_data),
    .i_n_oe           (n_oe),
    .i_n_we           (n_we),
    .o_drive          (drive),
    .o_wr_count       (wr_cnt),
    .o_rd_count       (rd_cnt),
    .o_err_contention (err_c),
    .o_err_timing     (err_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n-sample n_WE pulse; returns once the commit edge has passed.
  task automatic wr(input logic [19:0] a, input logic [7:0] d, input int n);
    addr = a; tb_wdata = d; tb_drv = 1'b1; n_we = 1'b0;
    cyc(n);
    n_we = 1'b1; tb_drv = 1'b0;
    cyc(2);
  endtask

  initial begin
    // 1: reset state
    #40;
    chk("rst_drive", drive, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_err_c", err_c, 0);
    chk("rst_err_t", err_t, 0);
    #2 rst = 1'b0;
    cyc(2);

    // 2: write then read 0x00012
    wr(20'h00012, 8'hA5, 3);
    chk("wr1_cnt", wr_cnt, 1);
    wr(20'h00013, 8'h3C, 2);
    chk("wr2_cnt", wr_cnt, 2);
    addr = 20'h00012; n_oe = 1'b0;
    cyc(2);
    chk("oe_lat_z", drive, 0);
    cyc(1);
    chk("oe_drive_on", drive, 1);
    chk("rd_cnt_wait", rd_cnt, 0);
    cyc(1);
    chk("rd_data_a5", io_data, 8'hA5);
    chk("rd_cnt1", rd_cnt, 1);

    // 3: address step holds old data through the new access latency
    addr = 20'h00013;
    cyc(1);
    chk("step_hold0", io_data, 8'hA5);
    cyc(1);
    chk("step_hold1", io_data, 8'hA5);
    chk("step_drive", drive, 1);
    cyc(1);
    chk("step_hold2", io_data, 8'hA5);
    chk("step_rd_cnt", rd_cnt, 1);
    cyc(1);
    chk("step_data_3c", io_data, 8'h3C);
    chk("rd_cnt2", rd_cnt, 2);
    chk("no_contention", err_c, 0);

    // 4: n_WE low while driving
    n_we = 1'b0; n_oe = 1'b1;
    cyc(2);
    chk("cont_set", err_c, 1);
    chk("cont_release", drive, 0);
    n_we = 1'b1;
    cyc(2);
    chk("cont_wr_cnt", wr_cnt, 3);
    cyc(3);
    chk("cont_sticky", err_c, 1);
    chk("cont_idle", drive, 0);

    // 5: aliasing 0x00105 / 0x00005
    wr(20'h00105, 8'h77, 2);
    chk("alias_wr_cnt", wr_cnt, 4);
    addr = 20'h00005; n_oe = 1'b0;
    cyc(4);
    chk("alias_data", io_data, 8'h77);
    chk("alias_rd_cnt", rd_cnt, 3);
    n_oe = 1'b1;
    cyc(2);
    chk("oe_off_release", drive, 0);

    // 6: single-sample n_WE pulse
    wr(20'h00005, 8'h99, 1);
    chk("short_wr_cnt", wr_cnt, WR_AFTER_SHORT);
    chk("short_err_t", err_t, ERR_T_SHORT);
    addr = 20'h00005; n_oe = 1'b0;
    cyc(4);
    chk("short_rd_data", io_data, RD_AFTER_SHORT);
    chk("short_rd_cnt", rd_cnt, 4);
    n_oe = 1'b1;
    cyc(2);

    // reset in the middle of a write: no commit, memory kept
    wr(20'h00020, 8'h5A, 2);
    chk("pre_rst_wr_cnt", wr_cnt, WR_AFTER_SHORT + 16'd1);
    addr = 20'h00020; tb_wdata = 8'hEE; tb_drv = 1'b1; n_we = 1'b0;
    cyc(3);
    rst = 1'b1; n_we = 1'b1; tb_drv = 1'b0;
    #1;
    chk("mid_wr_rst_cnt", wr_cnt, 0);
    chk("mid_wr_rst_err_c", err_c, 0);
    chk("mid_wr_rst_err_t", err_t, 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    n_oe = 1'b0;
    cyc(4);
    chk("no_commit_data", io_data, 8'h5A);
    chk("post_rst_rd_cnt", rd_cnt, 1);

    // reset in the middle of a read releases the bus immediately
    chk("pre_rst_drive", drive, 1);
    rst = 1'b1;
    #1;
    chk("mid_rd_rst_drive", drive, 0);
    n_oe = 1'b1;
    #5 rst = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
